// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse train generator: state encoding and
// the default counter width used by the top and the down counter.
package pulse_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pulse_state_e;

endpackage

// File: rtl/pulse_train_gen_counter.sv
// Loadable down counter. It counts down to 1 and then holds, so it never
// wraps even if the controller keeps asking for decrements.
module pg_down_counter
   import pulse_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] value,
   output logic             is_one
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] value_q;
   logic [CNT_W-1:0] value_d;

   // A load wins over a decrement; decrements stop once the count is 1.
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (dec && (value_q > ONE)) begin
         value_d = value_q - ONE;
      end
   end

   // Counter register, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value  = value_q;
   assign is_one = (value_q == ONE);

endmodule

// File: rtl/pulse_train_gen.sv
// Turns a single-cycle trigger into a train of N pulses, each H cycles high
// and separated by L low cycles. Config is captured on accepted triggers only.
module pulse_train_gen
   import pulse_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter bit RETRIGGER = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [CNT_W-1:0] count,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   pulse_state_e     state_q, state_d;
   logic [CNT_W-1:0] h_len_q, h_len_d;
   logic [CNT_W-1:0] l_len_q, l_len_d;
   logic             pulse_out_q, pulse_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             overrun_q, overrun_d;

   logic             ph_load, ph_dec, ph_is_one;
   logic [CNT_W-1:0] ph_load_val, ph_value;
   logic             pc_load, pc_dec, pc_is_one;
   logic [CNT_W-1:0] pc_value;

   logic             null_cfg;
   logic [CNT_W-1:0] low_eff;
   logic             in_train;

   assign null_cfg = (high_len == '0) || (count == '0);
   assign low_eff  = (low_len == '0) ? ONE : low_len;
   assign in_train = (state_q != IDLE);

   // Phase counter times the current HIGH or LOW interval.
   pg_down_counter #(.CNT_W(CNT_W)) u_phase_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ph_load),
      .load_val (ph_load_val),
      .dec      (ph_dec),
      .value    (ph_value),
      .is_one   (ph_is_one)
   );

   // Pulse counter tracks how many pulses remain, including the current one.
   pg_down_counter #(.CNT_W(CNT_W)) u_pulse_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (pc_load),
      .load_val (count),
      .dec      (pc_dec),
      .value    (pc_value),
      .is_one   (pc_is_one)
   );

   // Next-state logic: accepted triggers (re)start the train, otherwise the
   // counters walk through HIGH and LOW phases until the last pulse ends.
   always_comb begin
      state_d     = state_q;
      h_len_d     = h_len_q;
      l_len_d     = l_len_q;
      done_d      = 1'b0;
      overrun_d   = 1'b0;
      ph_load     = 1'b0;
      ph_load_val = h_len_q;
      ph_dec      = 1'b0;
      pc_load     = 1'b0;
      pc_dec      = 1'b0;

      if (trig && in_train) begin
         overrun_d = 1'b1;
      end

      if (trig && (!in_train || RETRIGGER)) begin
         if (null_cfg) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            h_len_d     = high_len;
            l_len_d     = low_eff;
            ph_load     = 1'b1;
            ph_load_val = high_len;
            pc_load     = 1'b1;
            state_d     = HIGH;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            HIGH: begin
               if (ph_is_one) begin
                  if (pc_is_one) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     ph_load     = 1'b1;
                     ph_load_val = l_len_q;
                     pc_dec      = 1'b1;
                     state_d     = LOW;
                  end
               end else begin
                  ph_dec = 1'b1;
               end
            end
            LOW: begin
               if (ph_is_one) begin
                  ph_load     = 1'b1;
                  ph_load_val = h_len_q;
                  state_d     = HIGH;
               end else begin
                  ph_dec = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      pulse_out_d = (state_d == HIGH);
      busy_d      = (state_d != IDLE);
   end

   // State, latched config and registered outputs; reset aborts any train.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         h_len_q     <= '0;
         l_len_q     <= '0;
         pulse_out_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_len_q     <= h_len_d;
         l_len_q     <= l_len_d;
         pulse_out_q <= pulse_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
      end
   end

   assign pulse_out = pulse_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen. Two instances share the stimulus:
// one ignores triggers while busy, the other restarts the train.
// Expected words are {pulse_out, busy, done, overrun}.
module tb_pulse_train_gen;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         trig;
   logic [W-1:0] high_len;
   logic [W-1:0] low_len;
   logic [W-1:0] count;

   logic pulse0, busy0, done0, ovr0;
   logic pulse1, busy1, done1, ovr1;

   int checks;
   int fails;

   pulse_train_gen #(.CNT_W(W), .RETRIGGER(1'b0)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig      (trig),
      .high_len  (high_len),
      .low_len   (low_len),
      .count     (count),
      .pulse_out (pulse0),
      .busy      (busy0),
      .done      (done0),
      .overrun   (ovr0)
   );

   pulse_train_gen #(.CNT_W(W), .RETRIGGER(1'b1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig      (trig),
      .high_len  (high_len),
      .low_len   (low_len),
      .count     (count),
      .pulse_out (pulse1),
      .busy      (busy1),
      .done      (done1),
      .overrun   (ovr1)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a config and raise trig for one cycle (lowered on the next tick).
   task automatic applyStimulus(input logic [W-1:0] h, input logic [W-1:0] l,
                                input logic [W-1:0] n);
      high_len = h;
      low_len  = l;
      count    = n;
      trig     = 1'b1;
   endtask

   // Compare both instances against their expected output words.
   task automatic checkOutput(input string tag, input int cyc,
                              input logic [3:0] exp0, input logic [3:0] exp1);
      logic [3:0] obs0;
      logic [3:0] obs1;
      obs0 = {pulse0, busy0, done0, ovr0};
      obs1 = {pulse1, busy1, done1, ovr1};
      checks++;
      assert (obs0 === exp0) else begin
         fails++;
         $display("[TB] FAIL %s rt0 cycle %0d observed=%b expected=%b", tag, cyc, obs0, exp0);
         $error("[TB] check %s rt0", tag);
      end
      checks++;
      assert (obs1 === exp1) else begin
         fails++;
         $display("[TB] FAIL %s rt1 cycle %0d observed=%b expected=%b", tag, cyc, obs1, exp1);
         $error("[TB] check %s rt1", tag);
      end
   endtask

   // Advance one cycle, drop trig, then compare.
   task automatic tickCheck(input string tag, input int cyc,
                            input logic [3:0] exp0, input logic [3:0] exp1);
      @(posedge clk);
      #1;
      trig = 1'b0;
      checkOutput(tag, cyc, exp0, exp1);
   endtask

   initial begin
      checks   = 0;
      fails    = 0;
      rst_n    = 1'b0;
      trig     = 1'b0;
      high_len = '0;
      low_len  = '0;
      count    = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", 0, 4'b0000, 4'b0000);
      rst_n = 1'b1;
      tickCheck("idle", 0, 4'b0000, 4'b0000);

      // H=3 L=2 N=2
      $display("[TB] basic train");
      applyStimulus(8'd3, 8'd2, 8'd2);
      for (int c = 1; c <= 3; c++) tickCheck("basic_hi1", c, 4'b1100, 4'b1100);
      high_len = 8'd9;
      count    = 8'd9;
      for (int c = 4; c <= 5; c++) tickCheck("basic_lo", c, 4'b0100, 4'b0100);
      for (int c = 6; c <= 8; c++) tickCheck("basic_hi2", c, 4'b1100, 4'b1100);
      tickCheck("basic_done", 9, 4'b0010, 4'b0010);
      tickCheck("basic_after", 10, 4'b0000, 4'b0000);

      // Null trains
      $display("[TB] null trains");
      applyStimulus(8'd0, 8'd2, 8'd2);
      tickCheck("null_h", 1, 4'b0010, 4'b0010);
      tickCheck("null_h_after", 2, 4'b0000, 4'b0000);
      applyStimulus(8'd3, 8'd2, 8'd0);
      tickCheck("null_n", 1, 4'b0010, 4'b0010);
      tickCheck("null_n_after", 2, 4'b0000, 4'b0000);

      // H=4 N=1, second trig at cycle 2 with H=2
      $display("[TB] busy trigger");
      applyStimulus(8'd4, 8'd1, 8'd1);
      tickCheck("busy_hi", 1, 4'b1100, 4'b1100);
      tickCheck("busy_hi", 2, 4'b1100, 4'b1100);
      applyStimulus(8'd2, 8'd1, 8'd1);
      tickCheck("busy_ovr", 3, 4'b1101, 4'b1101);
      tickCheck("busy_hi4", 4, 4'b1100, 4'b1100);
      tickCheck("busy_done", 5, 4'b0010, 4'b0010);
      tickCheck("busy_after", 6, 4'b0000, 4'b0000);
      tickCheck("busy_after", 7, 4'b0000, 4'b0000);

      // Retrigger with a null config while busy
      $display("[TB] busy null retrigger");
      applyStimulus(8'd3, 8'd1, 8'd1);
      tickCheck("rnull_hi", 1, 4'b1100, 4'b1100);
      applyStimulus(8'd3, 8'd1, 8'd0);
      tickCheck("rnull_ovr", 2, 4'b1101, 4'b0011);
      tickCheck("rnull_3", 3, 4'b1100, 4'b0000);
      tickCheck("rnull_4", 4, 4'b0010, 4'b0000);
      tickCheck("rnull_5", 5, 4'b0000, 4'b0000);

      // Trigger on the final HIGH cycle
      $display("[TB] trigger on last high");
      applyStimulus(8'd2, 8'd1, 8'd1);
      tickCheck("last_hi", 1, 4'b1100, 4'b1100);
      tickCheck("last_hi", 2, 4'b1100, 4'b1100);
      applyStimulus(8'd1, 8'd1, 8'd1);
      tickCheck("last_ovr", 3, 4'b0011, 4'b1101);
      tickCheck("last_4", 4, 4'b0000, 4'b0010);
      tickCheck("last_5", 5, 4'b0000, 4'b0000);

      // Reset in the middle of a train
      $display("[TB] reset mid-train");
      applyStimulus(8'd5, 8'd1, 8'd3);
      for (int c = 1; c <= 3; c++) tickCheck("rst_hi", c, 4'b1100, 4'b1100);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async", 3, 4'b0000, 4'b0000);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int c = 5; c <= 8; c++) tickCheck("rst_quiet", c, 4'b0000, 4'b0000);
      applyStimulus(8'd1, 8'd1, 8'd1);
      tickCheck("rst_new_hi", 1, 4'b1100, 4'b1100);
      tickCheck("rst_new_done", 2, 4'b0010, 4'b0010);
      tickCheck("rst_new_after", 3, 4'b0000, 4'b0000);

      // L=0 treated as 1
      $display("[TB] zero low length");
      applyStimulus(8'd1, 8'd0, 8'd3);
      tickCheck("l0_hi", 1, 4'b1100, 4'b1100);
      tickCheck("l0_lo", 2, 4'b0100, 4'b0100);
      tickCheck("l0_hi", 3, 4'b1100, 4'b1100);
      tickCheck("l0_lo", 4, 4'b0100, 4'b0100);
      tickCheck("l0_hi", 5, 4'b1100, 4'b1100);
      tickCheck("l0_done", 6, 4'b0010, 4'b0010);
      tickCheck("l0_after", 7, 4'b0000, 4'b0000);

      // Full-width high and low lengths
      $display("[TB] full-width lengths");
      applyStimulus(8'd255, 8'd255, 8'd1);
      for (int c = 1; c <= 255; c++) tickCheck("maxh_hi", c, 4'b1100, 4'b1100);
      tickCheck("maxh_done", 256, 4'b0010, 4'b0010);
      applyStimulus(8'd1, 8'd255, 8'd2);
      tickCheck("maxl_hi1", 1, 4'b1100, 4'b1100);
      for (int c = 2; c <= 256; c++) tickCheck("maxl_lo", c, 4'b0100, 4'b0100);
      tickCheck("maxl_hi2", 257, 4'b1100, 4'b1100);
      tickCheck("maxl_done", 258, 4'b0010, 4'b0010);
      tickCheck("maxl_after", 259, 4'b0000, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
